// File: rtl/regfile_sb.sv
// regfile_sb: bypassed multi-port integer register file with two
// prioritised write-back ports and a per-register busy scoreboard.
module regfile_sb #(
    parameter int DSIZE     = 32,
    parameter int ASIZE     = 5,
    parameter int NREG      = 32,
    parameter int NRD       = 2,
    parameter int INIT_ADDR = 1,
    parameter int INIT_VAL  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wen0,
    input  logic [ASIZE-1:0]   waddr0,
    input  logic [DSIZE-1:0]   wdata0,
    input  logic               wen1,
    input  logic [ASIZE-1:0]   waddr1,
    input  logic [DSIZE-1:0]   wdata1,
    input  logic [NRD*ASIZE-1:0] raddr,
    output logic [NRD*DSIZE-1:0] rdata,
    output logic [NRD-1:0]     rbusy,
    input  logic               res_en,
    input  logic [ASIZE-1:0]   res_addr,
    output logic               res_ok,
    output logic [ASIZE:0]     busy_cnt
);

    localparam int CW = ASIZE + 1;

    logic [DSIZE-1:0] mem [NREG];
    logic [NREG-1:0]  busy;
    logic [CW-1:0]    cnt;

    logic we0;
    logic we1;
    logic res_hit;
    logic res_busy;
    logic set;
    logic inc;
    logic c0;
    logic c1;

    function automatic logic in_range(input logic [ASIZE-1:0] a);
        return int'(a) < NREG;
    endfunction

    assign we0 = wen0 && waddr0 != '0 && in_range(waddr0);
    assign we1 = wen1 && waddr1 != '0 && in_range(waddr1);

    assign res_hit  = (wen0 && waddr0 == res_addr)
                   || (wen1 && waddr1 == res_addr);
    assign res_busy = in_range(res_addr) && busy[res_addr];
    assign res_ok   = res_en
                   && (res_addr == '0 || !res_busy || res_hit);
    assign set      = res_ok && res_addr != '0 && in_range(res_addr);

    // Only a free register can add to the count; a busy one that is
    // re-reserved must also be written this cycle, so it nets to zero.
    assign inc = set && !res_busy;
    assign c0  = we0 && busy[waddr0]
              && !(set && res_addr == waddr0);
    assign c1  = we1 && busy[waddr1]
              && !(we0 && waddr0 == waddr1)
              && !(set && res_addr == waddr1);

    assign busy_cnt = cnt;

    genvar k;
    for (k = 0; k < NRD; k++) begin : g_rd
        logic [ASIZE-1:0] a;
        logic             h0;
        logic             h1;

        assign a  = raddr[k*ASIZE +: ASIZE];
        assign h1 = wen1 && waddr1 == a;
        assign h0 = wen0 && waddr0 == a;

        assign rdata[k*DSIZE +: DSIZE] =
            (a == '0 || !in_range(a)) ? '0 :
            h1 ? wdata1 :
            h0 ? wdata0 : mem[a];

        assign rbusy[k] = a != '0 && in_range(a)
                       && busy[a] && !(h0 || h1);
    end

    // Array write-back: port 1 is applied last so it wins a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                if (INIT_ADDR != 0 && i == INIT_ADDR)
                    mem[i] <= DSIZE'(INIT_VAL);
                else
                    mem[i] <= '0;
            end
        end else begin
            if (we0) mem[waddr0] <= wdata0;
            if (we1) mem[waddr1] <= wdata1;
        end
    end

    // Scoreboard: clears first, then a reservation set overrides them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
            cnt  <= '0;
        end else begin
            if (we0) busy[waddr0] <= 1'b0;
            if (we1) busy[waddr1] <= 1'b0;
            if (set) busy[res_addr] <= 1'b1;
            cnt <= cnt + CW'(inc) - CW'(c0) - CW'(c1);
        end
    end

endmodule
